// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM encoding, frame constants, legal bit rates.
// Also used by the transmitter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int         DATA_BITS   = 8;
    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef struct packed {
        logic [5:0] prescale;
        logic       par_en;
        logic       par_typ;
    } rx_cfg_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, per-frame configuration and receive results of the UART receiver.
interface uart_rx_if;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    modport master (
        output RX_IN, prescale, par_en, par_typ,
        input  P_DATA, data_valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, prescale, par_en, par_typ,
        output P_DATA, data_valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler around the middle of each bit period.
// The sampled_bit output is registered and stays stable until the next bit's third sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] prescale,
    input  logic       rx_in,
    output logic       sampled_bit,
    output logic       sample_done
);

    logic [5:0] half, mid_lo, mid_hi;
    logic       s0, s1;

    assign half   = prescale >> 1;
    assign mid_lo = half - 6'd1;
    assign mid_hi = half + 6'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            sampled_bit <= 1'b0;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (edge_cnt == mid_lo) s0 <= rx_in;
            if (edge_cnt == half)   s1 <= rx_in;
            if (edge_cnt == mid_hi) begin
                sampled_bit <= majority3(s0, s1, rx_in);
                sample_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 / 8E1 / 8O1 frames at 8, 16 or 32 clocks per bit.
// The configuration is latched on start detect, and all result outputs are registered one-cycle pulses.
module uart_rx
    import uart_rx_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    rx_state_e  state;
    rx_cfg_t    cfg, cfg_in;
    logic [5:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, p_data;
    logic       dv, par_err, stp_err, par_bad, got_sample;
    logic       sampled_bit, sample_done, bit_end, start_ok;

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst         (rst),
        .edge_cnt    (edge_cnt),
        .prescale    (cfg.prescale),
        .rx_in       (bus.RX_IN),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done)
    );

    assign cfg_in   = '{prescale: bus.prescale, par_en: bus.par_en, par_typ: bus.par_typ};
    assign bit_end  = (edge_cnt == cfg.prescale - 6'd1);
    // A start bit with no sample taken (nonsense prescale) counts as a glitch.
    assign start_ok = (got_sample | sample_done) & (sampled_bit == START_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cfg        <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            p_data     <= '0;
            dv         <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            par_bad    <= 1'b0;
            got_sample <= 1'b0;
        end else begin
            dv      <= 1'b0;
            par_err <= 1'b0;
            stp_err <= 1'b0;
            if (sample_done) got_sample <= 1'b1;

            if (state == IDLE) begin
                edge_cnt <= '0;
                if (bus.RX_IN == START_BIT) begin
                    state      <= START;
                    bit_cnt    <= '0;
                    par_bad    <= 1'b0;
                    got_sample <= 1'b0;
                    cfg        <= cfg_in;
                end
            end else if (!bit_end) begin
                edge_cnt <= edge_cnt + 6'd1;
            end else begin
                edge_cnt   <= '0;
                got_sample <= 1'b0;
                case (state)
                    START: state <= start_ok ? DATA : IDLE;
                    DATA: begin
                        shreg   <= {sampled_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1))
                            state <= cfg.par_en ? PARITY : STOP;
                    end
                    PARITY: begin
                        if (sampled_bit != (^shreg ^ cfg.par_typ)) begin
                            par_err <= 1'b1;
                            par_bad <= 1'b1;
                        end
                        state <= STOP;
                    end
                    STOP: begin
                        if (sampled_bit != STOP_BIT) begin
                            stp_err <= 1'b1;
                        end else if (!par_bad) begin
                            p_data <= shreg;
                            dv     <= 1'b1;
                        end
                        // Back-to-back: a low line here is already the next start bit.
                        if (bus.RX_IN == START_BIT) begin
                            state   <= START;
                            bit_cnt <= '0;
                            par_bad <= 1'b0;
                            cfg     <= cfg_in;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.P_DATA       = p_data;
    assign bus.data_valid   = dv;
    assign bus.parity_error = par_err;
    assign bus.stop_error   = stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Random and directed frames against a frame-level model of expected pulses.
// Each expected pulse has a kind, an exact cycle and, for good frames, a data byte.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    uart_rx_if bus();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_VALID = 1;
    localparam int EV_PAR   = 2;
    localparam int EV_STOP  = 4;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model_pdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int k, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every output pulse is matched, in order, against the expected list.
    always @(negedge clk) begin
        logic [2:0] k;
        int         kind;
        ev_t        e;
        if (rst) begin
            k = {bus.stop_error, bus.parity_error, bus.data_valid};
            for (int b = 0; b < 3; b++) begin
                if (k[b]) begin
                    kind = 1 << b;
                    if (exp_q.size() == 0) begin
                        chk("spurious_pulse", kind, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_kind", kind, e.kind);
                        chk("ev_cycle", cyc, e.cyc);
                        if (kind == EV_VALID) chk("p_data", bus.P_DATA, e.data);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        tick(n);
    endtask

    function automatic int rand_p();
        int sel;
        sel = int'($urandom_range(0, 2));
        return 8 << sel;
    endfunction

    // Start detect happens on the edge after the line is driven low.
    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit par_flip, input bit stop_b, input bit scramble,
                              input int abort_bits);
        logic [10:0] bits;
        int          n, det, nb;
        bit          par_b;
        bus.prescale = 6'(p);
        bus.par_en   = pe;
        bus.par_typ  = pt;
        par_b = (^d) ^ pt ^ par_flip;
        n     = 10 + int'(pe);
        det   = cyc + 1;
        if (abort_bits == 0) begin
            if (pe && par_flip) push_ev(det + 10 * p, EV_PAR, 8'h00);
            if (!stop_b) begin
                push_ev(det + n * p, EV_STOP, 8'h00);
            end else if (!(pe && par_flip)) begin
                push_ev(det + n * p, EV_VALID, d);
                model_pdata = d;
            end
        end
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = par_b;
        bits[n-1] = stop_b;
        nb = (abort_bits != 0) ? abort_bits : n;
        for (int i = 0; i < nb; i++) begin
            bus.RX_IN = bits[i];
            if (scramble && i == 1) begin
                bus.prescale = 6'(rand_p());
                bus.par_en   = 1'($urandom);
                bus.par_typ  = 1'($urandom);
            end
            tick(p);
        end
    endtask

    task automatic glitch(input int p);
        bus.prescale = 6'(p);
        bus.RX_IN    = 1'b0;
        tick(2);
        idle(p + 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  p;
        bit  pe, pt, pf, sb, scr;
        bus.RX_IN    = 1'b1;
        bus.prescale = 6'd8;
        bus.par_en   = 1'b0;
        bus.par_typ  = 1'b0;
        rst = 1'b0;
        tick(3);
        chk("rst_p_data", bus.P_DATA, 8'h00);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_parity_error", bus.parity_error, 0);
        chk("rst_stop_error", bus.stop_error, 0);
        rst = 1'b1;
        idle(3);

        // good frame with even parity, latency 88
        send_frame(8, 1, 0, 8'h32, 0, 1, 0, 0);
        idle(4);
        chk("good_p_data", bus.P_DATA, 8'h32);

        // start glitch, then a clean frame
        glitch(8);
        send_frame(8, 0, 0, 8'hC3, 0, 1, 0, 0);
        idle(4);

        // parity error leaves P_DATA alone
        send_frame(8, 1, 0, 8'h32, 1, 1, 0, 0);
        idle(4);
        chk("par_err_hold", bus.P_DATA, model_pdata);

        // stop error at 160 cycles
        send_frame(16, 0, 0, 8'h5A, 0, 0, 0, 0);
        idle(4);
        chk("stop_err_hold", bus.P_DATA, 8'hC3);

        // back-to-back, odd parity, 352 cycles apart
        send_frame(32, 1, 1, 8'hA5, 0, 1, 0, 0);
        send_frame(32, 1, 1, 8'h3C, 0, 1, 0, 0);
        idle(4);
        chk("b2b_p_data", bus.P_DATA, 8'h3C);

        // reset in the middle of the data bits
        send_frame(8, 0, 0, 8'h81, 0, 1, 0, 4);
        rst = 1'b0;
        #1;
        chk("midrst_p_data", bus.P_DATA, 8'h00);
        chk("midrst_data_valid", bus.data_valid, 0);
        chk("midrst_parity_error", bus.parity_error, 0);
        chk("midrst_stop_error", bus.stop_error, 0);
        model_pdata = 8'h00;
        idle(2);
        rst = 1'b1;
        idle(2);
        send_frame(8, 0, 0, 8'hFF, 0, 1, 0, 0);
        idle(4);
        chk("post_rst_p_data", bus.P_DATA, 8'hFF);

        // random frames, random gaps, config scrambled mid-frame
        for (int it = 0; it < 40; it++) begin
            p   = rand_p();
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            pf  = ($urandom_range(0, 4) == 0);
            sb  = ($urandom_range(0, 4) != 0);
            scr = 1'($urandom);
            if ($urandom_range(0, 7) == 0) glitch(p);
            send_frame(p, pe, pt, 8'($urandom), pf, sb, scr, 0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(40);
        chk("missing_events", exp_q.size(), 0);
        chk("final_p_data", bus.P_DATA, model_pdata);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows: clk  in  1  system clock, all state on rising edge.
REQ-002 The block SHALL provide: rst  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL provide: RX_IN  in  1  serial line, idle high.
REQ-004 The block SHALL provide: prescale  in  6  clocks per bit; legal values are 8, 16 and 32.
REQ-005 The block SHALL provide: par_en  in  1  1 = parity bit present in the frame.
REQ-006 The block SHALL provide: par_typ  in  1  0 = even parity, 1 = odd parity.
REQ-007 The block SHALL provide: P_DATA  out  8  last correctly received byte.
REQ-008 The block SHALL provide: data_valid  out  1  one-cycle pulse, P_DATA is new.
REQ-009 The block SHALL provide: parity_error  out  1  one-cycle pulse, parity mismatch.
REQ-010 The block SHALL provide: stop_error  out  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-011 The frame format SHALL be: start bit (0), 8 data bits LSB first, an optional parity bit, and one stop bit (1).
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; the PARITY state is skipped when par_en = 0.
REQ-013 In IDLE, RX_IN = 0 on a rising clk edge SHALL move the FSM to START and clear edge_cnt to 0; prescale, par_en and par_typ SHALL be latched at this point and held for the whole frame.
REQ-014 edge_cnt SHALL count 0..prescale-1 within each bit; bit_cnt SHALL advance when edge_cnt wraps.
REQ-015 Each bit value SHALL be the 2-of-3 majority of RX_IN sampled at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
REQ-016 If the START majority value is 1 (glitch), the FSM SHALL return to IDLE at the end of the bit period, with no output pulse.
REQ-017 In DATA, data bits SHALL shift into an internal register; after 8 bits the FSM moves to PARITY or STOP.
REQ-018 In PARITY, the sampled bit SHALL be compared with XOR(data) for even parity or ~XOR(data) for odd parity.
REQ-019 On a parity mismatch, parity_error SHALL pulse for one cycle at the end of the parity bit, and the frame SHALL be discarded.
REQ-020 In STOP, a sample of 0 SHALL pulse stop_error for one cycle at the end of the stop bit.
REQ-021 If the frame is error-free, P_DATA SHALL be updated and data_valid SHALL pulse in the same cycle, at the end of the stop bit.
REQ-022 The data_valid latency SHALL be (10 + par_en) * prescale cycles after the start-detect edge.
REQ-023 On leaving STOP, the FSM SHALL enter IDLE; RX_IN = 0 in that same cycle SHALL be detected as the next start (back-to-back frames, no gap required).
REQ-024 P_DATA SHALL hold its value between frames; erroneous frames SHALL never alter it.
REQ-025 A frame that has both a parity error and a stop error SHALL pulse both error outputs in their respective cycles.
REQ-026 Changing prescale, par_en or par_typ mid-frame SHALL have no effect until the next start detection.
REQ-027 Behaviour for illegal prescale values is undefined, but the FSM SHALL NOT lock up; it returns to IDLE within one frame.

Reset
REQ-028 When rst = 0, all registers SHALL clear asynchronously: FSM to IDLE, edge_cnt = 0, bit_cnt = 0, P_DATA = 8'h00, data_valid = 0, parity_error = 0, stop_error = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes on the first start edge after rst returns to 1.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the frame constants DATA_BITS = 8, START_BIT = 0 and STOP_BIT = 1, and the legal prescale values; this package is shared with the transmitter.
REQ-031 One sub-module, uart_rx_sampler, SHALL implement the three-point majority sampler, taking edge_cnt, prescale and RX_IN and producing sampled_bit and sample_done.

Verification
REQ-032 Scenario, good frame with parity: prescale = 8, par_en = 1, par_typ = 0, send 0x32 with parity bit 1 -> P_DATA = 0x32 and a single data_valid pulse exactly 88 cycles after start detect.
REQ-033 Scenario, start glitch: prescale = 8, RX_IN low for 2 cycles, then high -> no outputs, FSM back in IDLE; a following good frame is received correctly.
REQ-034 Scenario, parity error: prescale = 8, par_en = 1, par_typ = 0, send 0x32 with parity bit 0 -> parity_error pulse, no data_valid, P_DATA unchanged.
REQ-035 Scenario, stop error: prescale = 16, par_en = 0, send 0x5A with stop bit 0 -> stop_error pulse 160 cycles after start detect, no data_valid.
REQ-036 Scenario, back-to-back frames: prescale = 32, par_en = 1, par_typ = 1, send 0xA5 then 0x3C with no idle gap -> two data_valid pulses 352 cycles apart, with P_DATA = 0xA5 and then 0x3C.
REQ-037 Scenario, reset mid-frame: assert rst during the DATA bits -> all outputs 0 immediately; the next full frame 0xFF (par_en = 0) gives P_DATA = 0xFF.
